pos_table_sweeper: RTL and testbench
====================================

// Module: pos_table_sweeper
// PURPOSE
//   Programmable product-of-sums evaluator with an automatic truth-table sweep.
//   A maxterm mask defines F(x[NVARS-1:0]) = PI M(i : mask[i]=1).
//   On start the block walks every input combination 0..2**NVARS-1, streams (index, S)
//   over a valid/ready port, and reports the number of zero rows.
//   Successor to the fixed 3/4-input PoS test blocks; feeds the truth-table checker/printer.
// PARAMETERS
//   NVARS   4            number of boolean inputs, legal 2..6
//   TT      2**NVARS     truth-table rows (derived localparam, not overridable)
// PORTS
//   clk           in   1        single clock, rising edge
//   rst_n         in   1        synchronous, active-low reset
//   start         in   1        request a sweep; sampled only in IDLE
//   maxterm_mask  in   TT       bit i=1 -> row i is a maxterm (S=0); captured on accepted start
//   busy          out  1        high in SWEEP and DONE
//   out_valid     out  1        row available
//   out_ready     in   1        consumer accepts row
//   out_index     out  NVARS    row number, MSB = first variable (x)
//   out_s         out  1        F value for out_index
//   done          out  1        one-cycle pulse after last row accepted
//   zero_count    out  NVARS+1  count of accepted rows with S=0
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, out_valid=0, out_index=0, out_s=0,
//     done=0, zero_count=0, mask register=0. Reset overrides everything, including mid-sweep.
//   FSM: IDLE -> SWEEP -> DONE -> IDLE.
//   IDLE: on start=1, mask_reg<=maxterm_mask, idx<=0, zero_count<=0, go to SWEEP.
//     Latency: start at edge t -> out_valid=1 with out_index=0 after edge t+1.
//   SWEEP: out_valid=1, out_index=idx, out_s=~mask_reg[idx] (registered state, comb output).
//     Transfer = out_valid & out_ready at a clk edge. On transfer:
//       zero_count += (out_s==0);
//       idx==TT-1 ? go to DONE : idx<=idx+1.
//     No transfer: idx, out_index and out_s hold stable (AXI-style, valid never drops).
//   DONE: out_valid=0, done=1 for exactly one cycle, then IDLE.
//   zero_count holds its final value until the next accepted start. Final value always
//     equals popcount(mask_reg); TT zeros (all-ones mask) fits in NVARS+1 bits.
//   start while busy: ignored, no effect on mask_reg or sweep.
//   maxterm_mask changes after capture: ignored until the next accepted start.
//   start held high: a new sweep begins in the cycle after DONE (IDLE lasts 1 cycle).
//   out_ready=1 throughout: start edge t -> done high after edge t+TT+1.
//   idx wraps never; the counter is NVARS bits and stops at TT-1.
// STRUCTURE
//   pos_pkg: state enum {IDLE, SWEEP, DONE} as localparams, NVARS_MAX=6,
//     function popcount for the bench reference model.
//   Sub-module pos_maxterm_eval (comb): inputs mask[TT], idx[NVARS] -> s = ~mask[idx];
//     reused by the bench as the golden PoS evaluator.
//   Top holds FSM, idx counter, zero counter, mask register.
// TESTING
//   T1 NVARS=3, mask=8'hCC (M 2,3,6,7), ready=1 -> S rows 0..7 = 1,1,0,0,1,1,0,0;
//      zero_count=4; done 9 cycles after start edge.
//   T2 NVARS=3, mask=8'hAD (M 0,2,3,5,7) -> S = 0,1,0,0,1,0,1,0; zero_count=5.
//   T3 NVARS=4, mask=16'h5157 (M 0,1,2,4,6,8,12,14) with out_ready toggling 1,0,0,1...
//      -> same 16 values in order, each held stable while stalled; zero_count=8.
//   T4 NVARS=4, rst_n=0 at row 5 of a sweep -> next edge all outputs at reset values,
//      state IDLE; fresh start with mask=16'h0000 -> all S=1, zero_count=0.
//   T5 start pulsed with mask B during a sweep of mask A -> sweep A completes unchanged,
//      no second sweep; mask=all-ones -> zero_count=TT.
//   T6 start held high across two sweeps -> exactly one IDLE cycle between done and
//      the next out_valid; zero_count cleared at second start.

Source files
------------

// File: rtl/pos_table_sweeper_pkg.sv
// Shared types and helpers for the product-of-sums truth-table sweeper.
package pos_table_sweeper_pkg;

  localparam int NVARS_MAX = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of maxterms in a mask, which is also the final zero_count of a sweep.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/pos_table_sweeper_maxterm_eval.sv
// Purpose: evaluates one product-of-sums row; s is 0 exactly when row idx is a maxterm.
// Latency: combinational.
// Backpressure: none, pure function of mask and idx.
module pos_maxterm_eval #(
  parameter int NVARS = 4
) (
  input  logic [(1 << NVARS)-1:0] mask,
  input  logic [NVARS-1:0]        idx,
  output logic                    s
);

  assign s = ~mask[idx];

endmodule

// File: rtl/pos_table_sweeper.sv
// Purpose: on start, streams (index, F) for every input combination and counts zero rows.
// Latency: first row valid one cycle after start is sampled; done one cycle after the last transfer.
// Backpressure: valid/ready; a stalled row holds index and value until accepted.
module pos_table_sweeper
  import pos_table_sweeper_pkg::*;
#(
  parameter int NVARS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1 << NVARS)-1:0] maxterm_mask,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NVARS-1:0]       out_index,
  output logic                   out_s,
  output logic                   done,
  output logic [NVARS:0]         zero_count
);

  localparam int TT = 1 << NVARS;
  localparam logic [NVARS-1:0] LAST_IDX = NVARS'(TT - 1);

  state_t            state;
  logic [NVARS-1:0]  idx;
  logic [TT-1:0]     mask_reg;
  logic              row_s;

  pos_maxterm_eval #(.NVARS(NVARS)) u_eval (
    .mask (mask_reg),
    .idx  (idx),
    .s    (row_s)
  );

  assign busy      = (state != IDLE);
  assign out_valid = (state == SWEEP);
  assign done      = (state == DONE);
  assign out_index = idx;
  // Gated so the value reads 0 outside a sweep, matching the reset value.
  assign out_s     = row_s & out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      mask_reg   <= '0;
      zero_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask_reg   <= maxterm_mask;
            idx        <= '0;
            zero_count <= '0;
            state      <= SWEEP;
          end
        end
        SWEEP: begin
          if (out_ready) begin
            zero_count <= zero_count + {{NVARS{1'b0}}, ~row_s};
            // idx parks on the last row rather than wrapping.
            if (idx == LAST_IDX) state <= DONE;
            else                 idx   <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_table_sweeper.sv
// Directed bench for pos_table_sweeper: a 3-variable and a 4-variable instance on one clock.
module tb_pos_table_sweeper;
  import pos_table_sweeper_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        start3, ready3, valid3, s3, done3, busy3;
  logic [7:0]  mask3;
  logic [2:0]  idx3;
  logic [3:0]  zc3;

  logic        start4, ready4, valid4, s4, done4, busy4;
  logic [15:0] mask4;
  logic [3:0]  idx4;
  logic [4:0]  zc4;

  int vectors;
  int miscompares;

  pos_table_sweeper #(.NVARS(3)) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start3),
    .maxterm_mask (mask3),
    .busy         (busy3),
    .out_valid    (valid3),
    .out_ready    (ready3),
    .out_index    (idx3),
    .out_s        (s3),
    .done         (done3),
    .zero_count   (zc3)
  );

  pos_table_sweeper #(.NVARS(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start4),
    .maxterm_mask (mask4),
    .busy         (busy4),
    .out_valid    (valid4),
    .out_ready    (ready4),
    .out_index    (idx4),
    .out_s        (s4),
    .done         (done4),
    .zero_count   (zc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // 3-variable sweep with ready held high; also measures start-to-done latency.
  task automatic sweep3(input string tag, input logic [7:0] m, input logic [7:0] exp_s,
                        input int expz);
    int row;
    int cyc;
    row = 0;
    cyc = 0;
    start3 = 1'b1;
    mask3  = m;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    mask3  = ~m;
    cyc = 1;
    while (done3 !== 1'b1 && cyc < 50) begin
      if (valid3 === 1'b1 && row < 8) begin
        check({tag, " index"}, 32'(idx3), 32'(row));
        check({tag, " s"}, 32'(s3), 32'(exp_s[row]));
        row++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check({tag, " rows"}, 32'(row), 32'd8);
    check({tag, " done latency"}, 32'(cyc), 32'd9);
    check({tag, " valid at done"}, 32'(valid3), 32'd0);
    check({tag, " zero_count"}, 32'(zc3), 32'(expz));
    @(posedge clk);
    @(negedge clk);
    check({tag, " done pulse width"}, 32'(done3), 32'd0);
    check({tag, " idle busy"}, 32'(busy3), 32'd0);
  endtask

  task automatic start_sweep4(input string tag, input logic [15:0] m, input logic hold);
    start4 = 1'b1;
    mask4  = m;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start4 = 1'b0;
    check({tag, " first valid"}, 32'(valid4), 32'd1);
    check({tag, " first index"}, 32'(idx4), 32'd0);
    check({tag, " cleared count"}, 32'(zc4), 32'd0);
  endtask

  // Walks the 16 rows under a repeating ready pattern; optionally pulses start mid-sweep.
  task automatic run_rows4(input string tag, input logic [15:0] exp_s, input logic [3:0] rdy_pat,
                           input int pulse_row, input logic [15:0] pulse_mask,
                           input logic drop_start, input int expz);
    int row;
    int k;
    int cyc;
    bit pulsed;
    row = 0;
    k = 0;
    cyc = 0;
    pulsed = 1'b0;
    while (row < 16 && cyc < 200) begin
      if (drop_start) start4 = 1'b0;
      ready4 = rdy_pat[k % 4];
      k++;
      if (pulse_row >= 0 && row == pulse_row && !pulsed) begin
        start4 = 1'b1;
        mask4  = pulse_mask;
        pulsed = 1'b1;
      end else if (pulsed) begin
        start4 = 1'b0;
      end
      check({tag, " valid"}, 32'(valid4), 32'd1);
      check({tag, " index"}, 32'(idx4), 32'(row));
      check({tag, " s"}, 32'(s4), 32'(exp_s[row]));
      @(posedge clk);
      if (ready4) row++;
      @(negedge clk);
      cyc++;
    end
    if (pulsed) start4 = 1'b0;
    ready4 = 1'b1;
    check({tag, " rows"}, 32'(row), 32'd16);
    check({tag, " done"}, 32'(done4), 32'd1);
    check({tag, " valid at done"}, 32'(valid4), 32'd0);
    check({tag, " busy at done"}, 32'(busy4), 32'd1);
    check({tag, " zero_count"}, 32'(zc4), 32'(expz));
  endtask

  initial begin
    int guard;
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    start3 = 1'b0;
    ready3 = 1'b1;
    mask3  = 8'h00;
    start4 = 1'b0;
    ready4 = 1'b1;
    mask4  = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy4), 32'd0);
    check("reset valid", 32'(valid4), 32'd0);
    check("reset index", 32'(idx4), 32'd0);
    check("reset s", 32'(s4), 32'd0);
    check("reset done", 32'(done4), 32'd0);
    check("reset zero_count", 32'(zc4), 32'd0);
    check("reset valid3", 32'(valid3), 32'd0);
    check("reset zero_count3", 32'(zc3), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // T1 / T2: 3-variable tables, ready always high.
    sweep3("T1", 8'hCC, 8'h33, 4);
    sweep3("T2", 8'hAD, 8'h52, 5);

    // T3: ready toggling 1,0,0,1; values must hold while stalled.
    start_sweep4("T3", 16'h5157, 1'b0);
    run_rows4("T3", 16'hAEA8, 4'b1001, -1, 16'h0000, 1'b0, 8);
    @(posedge clk);
    @(negedge clk);
    check("T3 done pulse width", 32'(done4), 32'd0);

    // T4: reset at row 5, then an all-zero mask sweep.
    start_sweep4("T4a", 16'hFFFF, 1'b0);
    guard = 0;
    while (idx4 !== 4'd5 && guard < 40) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("T4 reached row 5", 32'(idx4), 32'd5);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("T4 reset busy", 32'(busy4), 32'd0);
    check("T4 reset valid", 32'(valid4), 32'd0);
    check("T4 reset index", 32'(idx4), 32'd0);
    check("T4 reset s", 32'(s4), 32'd0);
    check("T4 reset done", 32'(done4), 32'd0);
    check("T4 reset zero_count", 32'(zc4), 32'd0);
    start_sweep4("T4b", 16'h0000, 1'b0);
    run_rows4("T4b", 16'hFFFF, 4'b1111, -1, 16'h0000, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);

    // T5: start with a different mask mid-sweep is ignored; then all-ones mask.
    start_sweep4("T5a", 16'h5157, 1'b0);
    run_rows4("T5a", 16'hAEA8, 4'b1111, 3, 16'hFFFF, 1'b0, 8);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("T5 no second sweep", 32'(valid4), 32'd0);
      check("T5 count held", 32'(zc4), 32'd8);
    end
    start_sweep4("T5b", 16'hFFFF, 1'b0);
    run_rows4("T5b", 16'h0000, 4'b1111, -1, 16'h0000, 1'b0, 16);
    @(posedge clk);
    @(negedge clk);

    // T6: start held high across two back-to-back sweeps.
    start_sweep4("T6a", 16'h0F0F, 1'b1);
    run_rows4("T6a", 16'hF0F0, 4'b1111, -1, 16'h0000, 1'b0, int'(popcount(64'h0F0F)));
    @(posedge clk);
    @(negedge clk);
    check("T6 idle valid", 32'(valid4), 32'd0);
    check("T6 idle busy", 32'(busy4), 32'd0);
    check("T6 idle done", 32'(done4), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("T6 restart valid", 32'(valid4), 32'd1);
    check("T6 restart index", 32'(idx4), 32'd0);
    check("T6 restart cleared", 32'(zc4), 32'd0);
    run_rows4("T6b", 16'hF0F0, 4'b1111, -1, 16'h0000, 1'b1, 8);
    @(posedge clk);
    @(negedge clk);
    check("T6 final idle valid", 32'(valid4), 32'd0);
    check("T6 final idle busy", 32'(busy4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
